// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared state encoding and default RAM base address
package ram_responder_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;
  localparam logic [63:0] RAM_BASE = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/ram_responder_bank.sv
// ram_bank: doubleword storage with one bit-masked write port and a write-first read port
module ram_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wmask_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] merged;
  // merged word is both the stored value and the bypassed read on a same-index collision
  always_comb begin
    merged = (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
    rdata_o = (we_i && waddr_i == raddr_i) ? merged : mem_q[raddr_i];
  end
  // masked write commit
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= merged;
endmodule

// File: rtl/ram_responder.sv
// ram_responder: RAM-side responder with zero-fill sweep, registered read and sticky range error.
// Optional access counters are enabled with RAM_ACCESS_CNT_EN.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RAM_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamReadEnable,
  input  logic [ADDR_W-1:0] RamReadAddr,
  output logic [DATA_W-1:0] RamReadData,
  output logic              ram_read_valid,
  input  logic              RamWriteEnable,
  input  logic [ADDR_W-1:0] RamWriteAddr,
  input  logic [DATA_W-1:0] RamWriteMask,
  input  logic [DATA_W-1:0] RamWriteData,
  output logic              ram_ready,
  output logic              ram_err
`ifdef RAM_ACCESS_CNT_EN
  ,
  output logic [31:0]       ram_rd_cnt,
  output logic [31:0]       ram_wr_cnt
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH) << 3;
  localparam int H = DATA_W / 2;
  state_e state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [DATA_W-1:0] rdata_q, rdata_d, b_rdata, b_wmask, b_wdata;
  logic rvalid_q, ready_q, err_q, err_d;
  logic [ADDR_W-1:0] roff, woff;
  logic rd_in, wr_in, rd_acc, wr_acc, init, b_we;
  logic [IDX_W-1:0] b_waddr;
  // range check, request acceptance, bank port muxing between sweep and core writes
  always_comb begin
    roff = RamReadAddr - BASE_ADDR;
    woff = RamWriteAddr - BASE_ADDR;
    rd_in = RamReadAddr >= BASE_ADDR && roff < LIMIT;
    wr_in = RamWriteAddr >= BASE_ADDR && woff < LIMIT;
    init = state_q == ST_INIT;
    rd_acc = !init && RamReadEnable;
    wr_acc = !init && RamWriteEnable;
    b_we = init || (wr_acc && wr_in);
    b_waddr = init ? cnt_q : woff[IDX_W+2:3];
    b_wmask = init ? '1 : RamWriteMask;
    b_wdata = init ? '0 : RamWriteData;
    rdata_d = !rd_acc ? rdata_q : !rd_in ? '0 :
              RamReadAddr[2] ? {b_rdata[H-1:0], b_rdata[DATA_W-1:H]} : b_rdata;
    err_d = err_q || (rd_acc && !rd_in) || (wr_acc && !wr_in);
  end
  ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
    .clk    (clk),
    .we_i   (b_we),
    .waddr_i(b_waddr),
    .wmask_i(b_wmask),
    .wdata_i(b_wdata),
    .raddr_i(roff[IDX_W+2:3]),
    .rdata_o(b_rdata)
  );
  // sweep FSM and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rd_acc;
      err_q <= err_d;
      if (init) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
      end
    end
  assign RamReadData = rdata_q;
  assign ram_read_valid = rvalid_q;
  assign ram_ready = ready_q;
  assign ram_err = err_q;
`ifdef RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  // saturating counts of accepted requests, in range or not
  always_ff @(posedge clk)
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (wr_acc && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  assign ram_rd_cnt = rd_cnt_q;
  assign ram_wr_cnt = wr_cnt_q;
`endif
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder at DEPTH=16
module tb_ram_responder;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic re = 1'b0, we = 1'b0;
  logic [63:0] raddr = '0, waddr = '0, wmask = '0, wdata = '0;
  logic [63:0] rdata;
  logic rvalid, ready, err;
  int total = 0, bad = 0;
  logic [64:0] sb[$];
  logic [64:0] exp_v, got_v;
`ifdef RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif
  ram_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .RamReadEnable(re), .RamReadAddr(raddr), .RamReadData(rdata), .ram_read_valid(rvalid),
    .RamWriteEnable(we), .RamWriteAddr(waddr), .RamWriteMask(wmask), .RamWriteData(wdata),
    .ram_ready(ready), .ram_err(err)
`ifdef RAM_ACCESS_CNT_EN
    , .ram_rd_cnt(rd_cnt), .ram_wr_cnt(wr_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_read(input logic [63:0] a, input logic v, input logic [63:0] e);
    re = 1'b1;
    raddr = a;
    sb.push_back({v, e});
    cyc();
    re = 1'b0;
    we = 1'b0;
  endtask
  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    we = 1'b1;
    waddr = a;
    wdata = d;
    wmask = m;
    cyc();
    we = 1'b0;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      cyc();
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    rst = 1'b1;
    cyc();
    cyc();
    total++;
    if ({ready, err, rvalid, rdata} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b err=%b valid=%b data=%h want all 0", ready, err, rvalid, rdata);
    end
    rst = 1'b0;
    issue_read(64'h8000_0000, 1'b0, 64'd0);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL init_read got %h want %h", got_v, exp_v);
    end
    wait_ready(n);
    n++;
    total++;
    if (n != DEPTH || !ready) begin
      bad++;
      $display("FAIL sweep_len got %0d cycles want %0d", n, DEPTH);
    end
  endtask
  task automatic test_masked_write();
    wr(64'h8000_0008, 64'h1122_3344_5566_7788, '1);
    wr(64'h8000_0008, 64'd0, 64'h0000_0000_FFFF_0000);
    issue_read(64'h8000_0008, 1'b1, 64'h1122_3344_0000_7788);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL masked_write got %h want %h", got_v, exp_v);
    end
  endtask
  task automatic test_word_select();
    issue_read(64'h8000_000C, 1'b1, 64'h0000_7788_1122_3344);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL word_select got %h want %h", got_v, exp_v);
    end
    total++;
    if (rdata[31:0] !== 32'h1122_3344) begin
      bad++;
      $display("FAIL word_select_lo got %h want 11223344", rdata[31:0]);
    end
  endtask
  task automatic test_back_to_back();
    we = 1'b1;
    waddr = 64'h8000_0010;
    wdata = 64'hDEAD_BEEF;
    wmask = '1;
    issue_read(64'h8000_0010, 1'b1, 64'hDEAD_BEEF);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL write_first got %h want %h", got_v, exp_v);
    end
    issue_read(64'h8000_0008, 1'b1, 64'h1122_3344_0000_7788);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL b2b_first got %h want %h", got_v, exp_v);
    end
    issue_read(64'h8000_000C, 1'b1, 64'h0000_7788_1122_3344);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL b2b_second got %h want %h", got_v, exp_v);
    end
    cyc();
    total++;
    if ({rvalid, rdata} !== {1'b0, 64'h0000_7788_1122_3344}) begin
      bad++;
      $display("FAIL idle_hold got valid=%b data=%h want valid=0 data=0000778811223344", rvalid, rdata);
    end
  endtask
  task automatic test_out_of_range();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got %b want 0", err);
    end
    issue_read(64'h7FFF_FFF8, 1'b1, 64'd0);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v || err !== 1'b1) begin
      bad++;
      $display("FAIL oor_read got %h err=%b want %h err=1", got_v, err, exp_v);
    end
    wr(64'h8000_0000 + DEPTH * 8, '1, '1);
    issue_read(64'h8000_0000, 1'b1, 64'd0);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v || err !== 1'b1) begin
      bad++;
      $display("FAIL oor_write_dropped got %h err=%b want %h err=1", got_v, err, exp_v);
    end
    we = 1'b1;
    waddr = 64'h8000_0018;
    wdata = 64'h0123_4567_89AB_CDEF;
    wmask = '1;
    issue_read(64'h0000_0000, 1'b1, 64'd0);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL oor_read_with_write got %h want %h", got_v, exp_v);
    end
    issue_read(64'h8000_0018, 1'b1, 64'h0123_4567_89AB_CDEF);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL write_beside_oor got %h want %h", got_v, exp_v);
    end
  endtask
  task automatic test_rst_mid_sweep();
    int n;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_sweep_ready got %b want 0", ready);
    end
    rst = 1'b1;
    cyc();
    total++;
    if ({ready, rvalid, err, rdata} !== 67'd0) begin
      bad++;
      $display("FAIL mid_sweep_rst got ready=%b valid=%b err=%b data=%h want all 0", ready, rvalid, err, rdata);
    end
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL resweep_len got %0d cycles want %0d", n, DEPTH);
    end
    issue_read(64'h8000_0010, 1'b1, 64'd0);
    exp_v = sb.pop_front();
    got_v = {rvalid, rdata};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL zero_fill got %h want %h", got_v, exp_v);
    end
    wr(64'h7FFF_FFF8, '1, '1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL oor_write_err got %b want 1", err);
    end
  endtask
`ifdef RAM_ACCESS_CNT_EN
  task automatic test_counters();
    int n;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
      bad++;
      $display("FAIL cnt_start got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    issue_read(64'h8000_0000, 1'b1, 64'd0);
    issue_read(64'h8000_0008, 1'b1, 64'd0);
    issue_read(64'h0000_0000, 1'b1, 64'd0);
    wr(64'h8000_0000, 64'd5, '1);
    wr(64'h0000_0000, 64'd5, '1);
    sb.delete();
    total++;
    if (rd_cnt !== 32'd3 || wr_cnt !== 32'd2) begin
      bad++;
      $display("FAIL cnt_value got rd=%0d wr=%0d want 3 2", rd_cnt, wr_cnt);
    end
    rst = 1'b1;
    cyc();
    total++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
      bad++;
      $display("FAIL cnt_rst got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    rst = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_masked_write();
    test_word_select();
    test_back_to_back();
    test_out_of_range();
    test_rst_mid_sweep();
`ifdef RAM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the core's RAM interface; the core is the initiator and drives the RamRead*/RamWrite* signals.
- Holds a doubleword-organised storage array serving instruction fetch and data access.
- Provides a registered read, a bit-masked write, an out-of-range error flag, and a post-reset zero-fill sweep.
- Sits at top level beside the core; in difftest it stands in for the external virtual RAM.

Parameters:
- ADDR_W, 64, byte address width (matches `ADDR_BUS).
- DATA_W, 64, data width (matches `DATA_BUS).
- DEPTH, 4096, number of doublewords; must be a power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of entry 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- RamReadEnable  in  1  read request this cycle.
- RamReadAddr  in  ADDR_W  byte read address.
- RamReadData  out  DATA_W  read data.
- ram_read_valid  out  1  RamReadData holds the result of the previous cycle's read.
- RamWriteEnable  in  1  write request this cycle.
- RamWriteAddr  in  ADDR_W  byte write address.
- RamWriteMask  in  DATA_W  per-bit write mask; 1 = update that bit.
- RamWriteData  in  DATA_W  write data.
- ram_ready  out  1  init sweep done; requests accepted.
- ram_err  out  1  sticky out-of-range access flag.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: RamReadData=0, ram_read_valid=0, ram_ready=0, ram_err=0, state=INIT, sweep counter=0.
- State machine, INIT: each cycle writes 0 to entry[cnt] and increments cnt. When cnt==DEPTH-1 it moves to READY, and ram_ready=1 from the next cycle. The sweep takes exactly DEPTH cycles. All requests are ignored in INIT: RamReadData stays 0, ram_read_valid=0, no writes.
- State machine, READY: stays until rst. rst in any state, including mid-sweep, restarts INIT with cnt=0.
- Indexing: idx = (addr - BASE_ADDR) >> 3. The address is in range iff addr >= BASE_ADDR and idx < DEPTH; subtraction is full ADDR_W wide.
- Read latency is 1 cycle. A read accepted at cycle t drives RamReadData and ram_read_valid=1 at t+1. With no read at t, ram_read_valid=0 at t+1 and RamReadData holds its last value.
- Word select: addr[2]==0 returns W = entry[idx]. addr[2]==1 returns {W[31:0], W[63:32]}, so the instruction at pc+4 is always in [31:0]. addr[1:0] is ignored.
- Write: entry[idx] <= (entry & ~mask) | (data & mask) at the clock edge. addr[2:0] is ignored; a mask of all zeros is a legal no-op.
- Same-cycle read and write to the same idx is write-first: the read returns the merged new value, then applies the word select.
- Out of range: the read returns 0 with ram_read_valid=1; the write is dropped. Either case sets ram_err=1, which stays set until rst.
- Simultaneous out-of-range read and in-range write: the write proceeds and ram_err is set.

Optional Feature:
- Macro: RAM_ACCESS_CNT_EN.
- Defined: adds outputs ram_rd_cnt[31:0] and ram_wr_cnt[31:0]. Each counts accepted READY-state requests, including out-of-range ones; both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- defines.v gains:
  - RAM_BASE default;
  - RAM_ST_INIT=1'b0 and RAM_ST_READY=1'b1;
  - a RAM_IDX_W width macro derived as log2 of DEPTH.
- Sub-module ram_bank: the storage array with one masked write port and one read port using write-first bypass.
- ram_responder keeps the FSM, sweep counter, range check, word select, output registers and the optional counters.

Test Plan:
- Reset then idle, DEPTH=16: ram_ready rises exactly 16 cycles after rst deasserts. A read of 64'h8000_0000 issued during INIT gives ram_read_valid=0 and RamReadData=0.
- Masked write and readback: write addr 64'h8000_0008, data 64'h1122_3344_5566_7788, mask all ones. Then write data 0 with mask 64'h0000_0000_FFFF_0000. Read 0x8000_0008 → 64'h1122_3344_0000_7788 one cycle later.
- Word select: read 64'h8000_000C → RamReadData=64'h0000_7788_1122_3344 with RamReadData[31:0]=32'h1122_3344.
- Same-cycle read and write to 64'h8000_0010 (data 64'hDEAD_BEEF, full mask): next-cycle RamReadData=64'hDEAD_BEEF.
- Out of range: read 64'h7FFF_FFF8 → RamReadData=0, ram_read_valid=1, ram_err=1. Write 64'h8000_0000+DEPTH*8 → memory unchanged and ram_err still 1.
- rst pulsed mid-sweep: ram_ready=0 and RamReadData=0, and the sweep restarts, taking a full DEPTH cycles. With RAM_ACCESS_CNT_EN, 3 reads and 2 writes give cnts 3 and 2, and both are 0 after rst.
